toggle_handshake_rx: RTL
========================

Name: toggle_handshake_rx

Overview:
- Receiving end of a two-phase toggle handshake. The transmitter flips a request line, built from a T flip-flop, once per transfer.
- This block synchronises the request line and detects each toggle. It captures the data word, hands it to a local consumer with valid/ready, and then toggles its own acknowledge line back to the transmitter.
- It keeps a wrapping transfer count and a sticky protocol-error flag.

Parameters:
- DW, 8, data word width.
- SYNC_STAGES, 2, flops in the request synchroniser chain; minimum 2.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_t  input  1  toggle request from the transmitter; asynchronous to clk.
- din  input  DW  data word; held stable by the transmitter from its req_t toggle until it sees ack_t toggle.
- ack_t  output  1  toggle acknowledge back to the transmitter.
- dout  output  DW  captured data word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout in any cycle where dout_valid=1 and dout_ready=1.
- evt_cnt  output  CNT_W  count of completed transfers.
- err  output  1  sticky flag: a req_t toggle arrived while a transfer was outstanding.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - ack_t=0, dout=0, dout_valid=0, evt_cnt=0, err=0, busy=1.
  - Synchroniser chain and the previous-value flop req_p are cleared to 0.
  - FSM is held in ARM.
- Synchroniser: req_s is req_t delayed through SYNC_STAGES flops. Toggle event tev = req_s XOR req_p, with req_p <= req_s every cycle.
- State ARM:
  - Counts SYNC_STAGES+1 cycles after rst deasserts, during which tev is ignored.
  - req_p tracks req_s during ARM, so a req_t already at 1 at reset release is not taken as a transfer.
  - Then goes to IDLE.
- State IDLE: busy=0. When tev=1:
  - dout <= din and dout_valid <= 1 in the same edge.
  - Go to HOLD.
- State HOLD: dout_valid=1. On a cycle with dout_ready=1:
  - dout_valid <= 0, ack_t <= ~ack_t, evt_cnt <= evt_cnt+1 (wraps modulo 2^CNT_W).
  - Go to IDLE.
- Latency:
  - A req_t toggle that meets setup before edge k gives dout_valid=1 after edge k+SYNC_STAGES.
  - ack_t toggles on the same edge that dout_valid falls.
  - With dout_ready held at 1, dout_valid is high for exactly 1 cycle.
- A tev=1 in HOLD:
  - Sets err (sticky until rst); the toggle is discarded.
  - dout is not overwritten; evt_cnt is unaffected.
- din is sampled only on the IDLE→HOLD edge; changes at any other time have no effect.
- dout holds its last value after consumption until the next capture.
- rst asserted mid-transfer:
  - Aborts the transfer and clears every output as listed above.
  - ack_t returns to 0. The transmitter must be reset together with this block to stay phase-aligned.
- Outputs are registered, with no combinational path from req_t or din.
  - Exception: busy decodes the state register only.
- FSM states, 2-bit encoding: ARM=0, IDLE=1, HOLD=2; code 3 is unused and recovers to ARM.

Decomposition:
- Shared package holds:
  - the state enum (ARM, IDLE, HOLD);
  - the default widths DW_DEF=8 and CNT_W_DEF=8;
  - the SYNC_STAGES minimum of 2.
- One sub-module, toggle_sync_det:
  - contains the synchroniser chain, the req_p flop and the XOR;
  - ports clk, rst, req_t, arm_en, tev.
- FSM, data register and counter stay in toggle_handshake_rx.

Test Plan:
- Reset release with req_t=1 held: after 10 cycles dout_valid=0, err=0, evt_cnt=0, busy=0.
- Single transfer, dout_ready tied to 1: din=8'hA5, req_t 0→1 → dout=A5 and dout_valid pulse of 1 cycle, 3 cycles after the toggle; ack_t=1 and evt_cnt=1 on the same edge that dout_valid falls.
- Backpressure: din=8'h3C, toggle, dout_ready=0 for 5 cycles then 1 → dout_valid held 5 cycles plus the accept cycle; dout=3C throughout; ack_t toggles only on the accept edge.
- Overrun: second req_t toggle with din=8'hFF while in HOLD holding 8'h11 → err=1 and stays 1; dout stays 11; evt_cnt increments by 1 only.
- Counter wrap: 256 back-to-back transfers with alternating req_t → evt_cnt returns to 0 and ack_t ends at 0.
- Reset mid-HOLD: rst pulsed while dout_valid=1 → dout_valid, ack_t, evt_cnt, err all 0 asynchronously, before the next clock edge; FSM re-arms; the next transfer completes normally.

Source files
------------

// File: rtl/toggle_handshake_rx_pkg.sv
// Shared types and defaults for the toggle-handshake receiver.
package toggle_handshake_rx_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DW_DEF          = 8;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/toggle_handshake_rx_sync_det.sv
// Request-line synchroniser and toggle detector; detection is masked while arm_en=0.
module toggle_sync_det
  import toggle_handshake_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic req_t,
  input  logic arm_en,
  output logic tev
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_p_q, req_p_d;
  logic                   req_s;

  // req_p follows req_s even while masked, so a level present at arm time is not an event
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req_t};
    req_s   = sync_q[SYNC_STAGES-1];
    req_p_d = req_s;
    tev     = arm_en & (req_s ^ req_p_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      req_p_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      req_p_q <= req_p_d;
    end
  end

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle handshake: captures din on each req_t toggle,
// presents it with valid/ready, then toggles ack_t back to the transmitter.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_t,
  input  logic [DW-1:0]    din,
  output logic             ack_t,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err,
  output logic             busy
);

  localparam int              ARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES);

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic               ack_t_q, ack_t_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic               err_q, err_d;
  logic               arm_en;
  logic               tev;

  assign arm_en = (state_q != ARM);

  toggle_sync_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_det (
    .clk   (clk),
    .rst   (rst),
    .req_t (req_t),
    .arm_en(arm_en),
    .tev   (tev)
  );

  always_comb begin
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    ack_t_d      = ack_t_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    evt_cnt_d    = evt_cnt_q;
    err_d        = err_q;
    case (state_q)
      ARM: begin
        if (arm_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (tev) begin
          dout_d       = din;
          dout_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // a toggle here is an overrun: flag it and drop it
        if (tev) begin
          err_d = 1'b1;
        end
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          ack_t_d      = ~ack_t_q;
          evt_cnt_d    = evt_cnt_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = ARM;
        arm_cnt_d    = ARM_LOAD;
        dout_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARM;
      arm_cnt_q    <= ARM_LOAD;
      ack_t_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      evt_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      ack_t_q      <= ack_t_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      evt_cnt_q    <= evt_cnt_d;
      err_q        <= err_d;
    end
  end

  assign ack_t      = ack_t_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign evt_cnt    = evt_cnt_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule
